// File: rtl/scan_capture.sv
// Captures row-scanned RGB matrix bus samples into a double-buffered 8x24 frame store.
// Rows must arrive 0..7 in order; a completed frame swaps into the display bank atomically.
module scan_capture #(
  parameter int unsigned TIMEOUT_CYC = 200000
) (
  input  logic        CLK,
  input  logic        reset,
  input  logic        scan_clk,
  input  logic [0:27] scan_bus,
  input  logic [2:0]  rd_row,
  output logic [23:0] rd_data,
  output logic        frame_valid,
  output logic [7:0]  frame_cnt,
  output logic [7:0]  err_cnt,
  output logic        locked,
  output logic        scan_lost
);

  localparam int unsigned CNT_W = $clog2(TIMEOUT_CYC + 1);
  localparam logic [CNT_W-1:0] TO_MAX = CNT_W'(TIMEOUT_CYC);
  localparam int unsigned ROWS = 8;

  typedef enum logic {S_HUNT, S_CAPTURE} state_t;

  state_t state, state_d;
  logic [2:0] exp_row, exp_row_d;

  logic sync1, sync2, hist;
  logic edge_e, sample, timed_out;
  logic wr_en, swap, err_inc;

  logic [2:0]  bus_row;
  logic        bus_en;
  logic [23:0] bus_pix;

  logic [CNT_W-1:0] to_cnt;
  logic [23:0] bank0 [ROWS];
  logic [23:0] bank1 [ROWS];
  logic        disp_sel;

  // Column lines are active-low on the bus; store them active-high.
  assign bus_row = scan_bus[24:26];
  assign bus_en  = scan_bus[27];
  assign bus_pix = ~scan_bus[0:23];

  assign edge_e    = hist & ~sync2;
  assign sample    = edge_e & bus_en;
  assign timed_out = (to_cnt == TO_MAX) && !edge_e;

  // scan_clk synchronizer and falling-edge history
  always_ff @(posedge CLK or negedge reset) begin
    if (!reset) begin
      sync1 <= 1'b0;
      sync2 <= 1'b0;
      hist  <= 1'b0;
    end else begin
      sync1 <= scan_clk;
      sync2 <= sync1;
      hist  <= sync2;
    end
  end

  // FSM state register
  always_ff @(posedge CLK or negedge reset) begin
    if (!reset) begin
      state   <= S_HUNT;
      exp_row <= 3'd0;
    end else begin
      state   <= state_d;
      exp_row <= exp_row_d;
    end
  end

  // FSM next-state and capture control
  always_comb begin
    state_d   = state;
    exp_row_d = exp_row;
    wr_en     = 1'b0;
    swap      = 1'b0;
    err_inc   = 1'b0;
    if (timed_out) begin
      state_d   = S_HUNT;
      exp_row_d = 3'd0;
    end else if (sample) begin
      case (state)
        S_HUNT: begin
          if (bus_row == 3'd0) begin
            wr_en     = 1'b1;
            exp_row_d = 3'd1;
            state_d   = S_CAPTURE;
          end
        end
        S_CAPTURE: begin
          if (bus_row == exp_row) begin
            wr_en     = 1'b1;
            exp_row_d = exp_row + 3'd1;
            swap      = (exp_row == 3'd7);
          end else begin
            err_inc = 1'b1;
            if (bus_row == 3'd0) begin
              // Treat a stray row 0 as the start of a fresh frame.
              wr_en     = 1'b1;
              exp_row_d = 3'd1;
            end else begin
              state_d   = S_HUNT;
              exp_row_d = 3'd0;
            end
          end
        end
        default: begin
          state_d   = S_HUNT;
          exp_row_d = 3'd0;
        end
      endcase
    end
  end

  // Link watchdog: any falling edge restarts it, it saturates at TIMEOUT_CYC
  always_ff @(posedge CLK or negedge reset) begin
    if (!reset) begin
      to_cnt    <= '0;
      scan_lost <= 1'b0;
    end else begin
      if (edge_e) begin
        to_cnt <= '0;
      end else if (to_cnt != TO_MAX) begin
        to_cnt <= to_cnt + CNT_W'(1);
      end
      if (sample) begin
        scan_lost <= 1'b0;
      end else if (timed_out) begin
        scan_lost <= 1'b1;
      end
    end
  end

  // Status outputs
  always_ff @(posedge CLK or negedge reset) begin
    if (!reset) begin
      frame_valid <= 1'b0;
      frame_cnt   <= 8'd0;
      err_cnt     <= 8'd0;
      locked      <= 1'b0;
    end else begin
      frame_valid <= swap;
      if (swap) begin
        frame_cnt <= frame_cnt + 8'd1;
      end
      if (err_inc && (err_cnt != 8'hFF)) begin
        err_cnt <= err_cnt + 8'd1;
      end
      locked <= (state_d == S_CAPTURE);
    end
  end

  // Double-buffered frame store; writes only ever target the capture bank
  always_ff @(posedge CLK or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < ROWS; i++) begin
        bank0[i] <= '0;
        bank1[i] <= '0;
      end
      disp_sel <= 1'b0;
    end else begin
      if (wr_en) begin
        if (disp_sel) begin
          bank0[bus_row] <= bus_pix;
        end else begin
          bank1[bus_row] <= bus_pix;
        end
      end
      if (swap) begin
        disp_sel <= ~disp_sel;
      end
    end
  end

  always_comb begin
    rd_data = disp_sel ? bank1[rd_row] : bank0[rd_row];
  end

endmodule

// File: tb/tb_scan_capture.sv
// Directed bench for scan_capture: table of row samples with expected status, plus
// hand-written timeout, asynchronous reset and reset-release sequences.
module tb_scan_capture;

  localparam int unsigned TO = 1000;

  logic        CLK = 1'b0;
  logic        reset;
  logic        scan_clk;
  logic [0:27] scan_bus;
  logic [2:0]  rd_row;
  logic [23:0] rd_data;
  logic        frame_valid;
  logic [7:0]  frame_cnt;
  logic [7:0]  err_cnt;
  logic        locked;
  logic        scan_lost;

  scan_capture #(.TIMEOUT_CYC(TO)) dut (
    .CLK         (CLK),
    .reset       (reset),
    .scan_clk    (scan_clk),
    .scan_bus    (scan_bus),
    .rd_row      (rd_row),
    .rd_data     (rd_data),
    .frame_valid (frame_valid),
    .frame_cnt   (frame_cnt),
    .err_cnt     (err_cnt),
    .locked      (locked),
    .scan_lost   (scan_lost)
  );

  initial forever #5 CLK = ~CLK;

  typedef struct {
    bit          rst;
    bit          en;
    logic [2:0]  row;
    logic [7:0]  pat;
    bit          exp_locked;
    int          exp_err;
    int          exp_frames;
    int          exp_fv;
    logic [23:0] exp_rd3;
  } vec_t;

  vec_t tbl[$];
  int   n_chk = 0;
  int   n_fail = 0;
  int   fv_total = 0;
  int   fv_double = 0;
  int   fv_base = 0;
  logic fv_prev = 1'b0;

  // Pulse monitor, sampled away from the active edge
  always @(negedge CLK) begin
    if (frame_valid) begin
      fv_total++;
      if (fv_prev) fv_double++;
    end
    fv_prev = frame_valid;
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  function automatic logic [0:27] mk_bus(input logic [2:0] row, input logic [7:0] pat,
                                         input logic en);
    logic [7:0] g;
    g = ~(8'd1 << row);
    return {~pat, g, 8'hFF, row, en};
  endfunction

  task automatic add(input bit rst, input bit en, input int row, input int pat, input bit lk,
                     input int er, input int fr, input int fv, input logic [23:0] rd);
    vec_t v;
    v.rst = rst; v.en = en; v.row = 3'(row); v.pat = 8'(pat);
    v.exp_locked = lk; v.exp_err = er; v.exp_frames = fr; v.exp_fv = fv; v.exp_rd3 = rd;
    tbl.push_back(v);
  endtask

  // One scan row: bus set up, scan_clk high, then falling edge with bus held stable
  task automatic send(input logic [2:0] row, input logic [7:0] pat, input logic en);
    @(negedge CLK);
    scan_bus = mk_bus(row, pat, en);
    scan_clk = 1'b1;
    repeat (4) @(negedge CLK);
    scan_clk = 1'b0;
    repeat (6) @(negedge CLK);
  endtask

  task automatic do_reset();
    @(negedge CLK);
    reset = 1'b0;
    repeat (2) @(negedge CLK);
    reset = 1'b1;
    repeat (2) @(negedge CLK);
    fv_base = fv_total;
  endtask

  initial begin
    reset    = 1'b0;
    scan_clk = 1'b0;
    scan_bus = '0;
    rd_row   = 3'd3;

    // Clean frame, green column r lit on row r
    for (int r = 0; r < 8; r++)
      add(r == 0, 1, r, 'h00, 1, 0, (r == 7) ? 1 : 0, (r == 7) ? 1 : 0,
          (r == 7) ? 24'h000800 : 24'h0);
    // Out of order 0,1,2,5 then 6,7 discarded; display holds the previous frame
    add(0, 1, 0, 'h33, 1, 0, 1, 1, 24'h000800);
    add(0, 1, 1, 'h33, 1, 0, 1, 1, 24'h000800);
    add(0, 1, 2, 'h33, 1, 0, 1, 1, 24'h000800);
    add(0, 1, 5, 'h33, 0, 1, 1, 1, 24'h000800);
    add(0, 1, 6, 'h33, 0, 1, 1, 1, 24'h000800);
    add(0, 1, 7, 'h33, 0, 1, 1, 1, 24'h000800);
    for (int r = 0; r < 8; r++)
      add(0, 1, r, 'h22, 1, 1, (r == 7) ? 2 : 1, (r == 7) ? 2 : 1,
          (r == 7) ? 24'h220800 : 24'h000800);
    // Duplicate row 0
    add(1, 1, 0, 'h44, 1, 0, 0, 0, 24'h0);
    add(0, 1, 0, 'h44, 1, 1, 0, 0, 24'h0);
    for (int r = 1; r < 8; r++)
      add(0, 1, r, 'h44, 1, 1, (r == 7) ? 1 : 0, (r == 7) ? 1 : 0,
          (r == 7) ? 24'h440800 : 24'h0);
    // Disabled row-4 sample carrying junk is ignored
    for (int r = 0; r < 4; r++)
      add(r == 0, 1, r, 'h55, 1, 0, 0, 0, 24'h0);
    add(0, 0, 4, 'hAA, 1, 0, 0, 0, 24'h0);
    for (int r = 4; r < 8; r++)
      add(0, 1, r, 'h55, 1, 0, (r == 7) ? 1 : 0, (r == 7) ? 1 : 0,
          (r == 7) ? 24'h550800 : 24'h0);

    // Values while held in reset
    repeat (3) @(negedge CLK);
    chk("rst_rd_data", 32'(rd_data), 32'h0);
    chk("rst_frame_valid", 32'(frame_valid), 32'h0);
    chk("rst_frame_cnt", 32'(frame_cnt), 32'h0);
    chk("rst_err_cnt", 32'(err_cnt), 32'h0);
    chk("rst_locked", 32'(locked), 32'h0);
    chk("rst_scan_lost", 32'(scan_lost), 32'h0);

    // Falling edge coincident with reset release, row 0 on the bus
    scan_bus = mk_bus(3'd0, 8'h12, 1'b1);
    scan_clk = 1'b1;
    @(negedge CLK);
    reset    = 1'b1;
    scan_clk = 1'b0;
    repeat (8) @(negedge CLK);
    chk("release_edge_locked", 32'(locked), 32'h0);
    chk("release_edge_rd", 32'(rd_data), 32'h0);

    foreach (tbl[i]) begin
      if (tbl[i].rst) do_reset();
      send(tbl[i].row, tbl[i].pat, tbl[i].en);
      rd_row = 3'd3;
      #1;
      chk($sformatf("vec%0d_locked", i), 32'(locked), 32'(tbl[i].exp_locked));
      chk($sformatf("vec%0d_err_cnt", i), 32'(err_cnt), 32'(tbl[i].exp_err));
      chk($sformatf("vec%0d_frame_cnt", i), 32'(frame_cnt), 32'(tbl[i].exp_frames));
      chk($sformatf("vec%0d_fv_pulses", i), 32'(fv_total - fv_base), 32'(tbl[i].exp_fv));
      chk($sformatf("vec%0d_rd_row3", i), 32'(rd_data), 32'(tbl[i].exp_rd3));
    end

    // Every row of the last frame, rd_row combinational
    for (int r = 0; r < 8; r++) begin
      logic [7:0] g;
      g = 8'd1 << r;
      rd_row = 3'(r);
      #1;
      chk($sformatf("frame_row%0d", r), 32'(rd_data), 32'({8'h55, g, 8'h00}));
    end

    // Timeout: scan_clk stops after row 4
    do_reset();
    for (int r = 0; r < 5; r++) send(3'(r), 8'h66, 1'b1);
    chk("to_pre_locked", 32'(locked), 32'h1);
    repeat (890) @(negedge CLK);
    chk("to_early_lost", 32'(scan_lost), 32'h0);
    chk("to_early_locked", 32'(locked), 32'h1);
    repeat (120) @(negedge CLK);
    chk("to_lost", 32'(scan_lost), 32'h1);
    chk("to_locked", 32'(locked), 32'h0);
    chk("to_err", 32'(err_cnt), 32'h0);
    send(3'd5, 8'h66, 1'b1);
    chk("to_resume_lost", 32'(scan_lost), 32'h0);
    chk("to_resume_locked", 32'(locked), 32'h0);
    chk("to_resume_err", 32'(err_cnt), 32'h0);
    send(3'd6, 8'h66, 1'b1);
    send(3'd7, 8'h66, 1'b1);
    chk("to_tail_frames", 32'(frame_cnt), 32'h0);
    chk("to_tail_fv", 32'(fv_total - fv_base), 32'h0);
    for (int r = 0; r < 8; r++) send(3'(r), 8'h66, 1'b1);
    rd_row = 3'd3;
    #1;
    chk("to_full_frames", 32'(frame_cnt), 32'h1);
    chk("to_full_err", 32'(err_cnt), 32'h0);
    chk("to_full_rd", 32'(rd_data), 32'h660800);

    // Asynchronous reset in the middle of the second frame
    do_reset();
    for (int r = 0; r < 8; r++) send(3'(r), 8'h77, 1'b1);
    for (int r = 0; r < 6; r++) send(3'(r), 8'h88, 1'b1);
    rd_row = 3'd3;
    #1;
    chk("mid_pre_rd", 32'(rd_data), 32'h770800);
    chk("mid_pre_frames", 32'(frame_cnt), 32'h1);
    @(negedge CLK);
    reset = 1'b0;
    #1;
    chk("mid_rst_rd", 32'(rd_data), 32'h0);
    chk("mid_rst_frames", 32'(frame_cnt), 32'h0);
    chk("mid_rst_locked", 32'(locked), 32'h0);
    chk("mid_rst_err", 32'(err_cnt), 32'h0);
    chk("mid_rst_lost", 32'(scan_lost), 32'h0);
    chk("mid_rst_fv", 32'(frame_valid), 32'h0);
    repeat (3) @(negedge CLK);
    reset = 1'b1;
    fv_base = fv_total;
    send(3'd6, 8'h88, 1'b1);
    send(3'd7, 8'h88, 1'b1);
    chk("mid_tail_locked", 32'(locked), 32'h0);
    chk("mid_tail_frames", 32'(frame_cnt), 32'h0);
    for (int r = 0; r < 8; r++) send(3'(r), 8'h99, 1'b1);
    rd_row = 3'd3;
    #1;
    chk("mid_full_frames", 32'(frame_cnt), 32'h1);
    chk("mid_full_err", 32'(err_cnt), 32'h0);
    chk("mid_full_fv", 32'(fv_total - fv_base), 32'h1);
    chk("mid_full_rd", 32'(rd_data), 32'h990800);
    chk("mid_full_locked", 32'(locked), 32'h1);

    chk("fv_back_to_back", 32'(fv_double), 32'h0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/scan_capture.md
SCAN_CAPTURE -- requirements
Module: scan_capture

Interface
REQ-001 SHALL have parameter TIMEOUT_CYC, default 200000: the number of CLK cycles without a scan_clk falling edge before the link is declared lost.
REQ-002 SHALL have port CLK, input, 1: system clock; all state changes on posedge CLK.
REQ-003 SHALL have port reset, input, 1: asynchronous, active-low reset.
REQ-004 SHALL have port scan_clk, input, 1: divided scan clock from the matrix driver, asynchronous to CLK.
REQ-005 SHALL have port scan_bus, input, [0:27]: matrix bus, laid out as follows.
  - [0:7] red columns, active-low.
  - [8:15] green columns, active-low.
  - [16:23] blue columns, active-low.
  - [24:26] row index.
  - [27] enable.
REQ-006 SHALL have port rd_row, input, 3: row select for the read port.
REQ-007 SHALL have port rd_data, output, 24: row rd_row of the displayed frame, {R[7:0],G[7:0],B[7:0]}, active-high (1 = lit), combinational from the display bank.
REQ-008 SHALL have port frame_valid, output, 1: one-cycle pulse on each frame swap.
REQ-009 SHALL have port frame_cnt, output, 8: count of completed frames; wraps 255->0.
REQ-010 SHALL have port err_cnt, output, 8: count of sequence errors; saturates at 255.
REQ-011 SHALL have port locked, output, 1: high while in state CAPTURE.
REQ-012 SHALL have port scan_lost, output, 1: high while the timeout has expired; cleared by the next accepted sample.

Function
REQ-013 SHALL pass scan_clk through a 2-flop synchronizer plus one history flop; a falling edge is detected when history=1 and the sync output is 0, and that CLK cycle is cycle E.
REQ-014 SHALL sample scan_bus in cycle E only (falling edge = mid-stable point of the bus); bus values at any other time SHALL have no effect.
REQ-015 SHALL ignore a sample with scan_bus[27]=0: no state, buffer or counter change, but the timeout counter is still cleared.
REQ-016 SHALL hold two 8x24 banks (capture and display), storing inverted column data, so that rd_data bit = ~bus bit.
REQ-017 SHALL implement the FSM {HUNT, CAPTURE} with an expected-row register exp_row[2:0].
REQ-018 In HUNT: a sample with row=0 SHALL write capture row 0, set exp_row=1 and go to CAPTURE; any other row SHALL be discarded, with no error counted.
REQ-019 In CAPTURE with row==exp_row: SHALL write the capture row and set exp_row=exp_row+1 (mod 8).
REQ-020 In CAPTURE with row==exp_row==7: SHALL, in addition, swap the banks at the end of cycle E.
  - frame_valid=1 in cycle E+1.
  - frame_cnt incremented, visible in E+1.
  - rd_data shows the new frame from E+1.
  - exp_row=0; state stays CAPTURE.
REQ-021 In CAPTURE with row!=exp_row (out of order, duplicate or skip): SHALL increment err_cnt (saturating) and discard the partial frame.
  - If row==0: treat as a fresh start per REQ-018 (write row 0, exp_row=1, stay CAPTURE).
  - Otherwise: go to HUNT.
REQ-022 The display bank SHALL never be written directly; a partial or erroneous frame SHALL never reach rd_data.
REQ-023 SHALL clear the timeout counter on every cycle E.
  - It otherwise increments, saturating at TIMEOUT_CYC.
  - On reaching TIMEOUT_CYC: scan_lost=1, state=HUNT, no err_cnt change.
REQ-024 The first accepted sample after timeout SHALL clear scan_lost in the following cycle and be processed normally.
REQ-025 The counter width SHALL be ceil(log2(TIMEOUT_CYC+1)) bits.
REQ-026 frame_valid SHALL never be high for two consecutive cycles.
REQ-027 rd_row changes SHALL affect rd_data in the same cycle, with zero latency.

Reset
REQ-028 While reset=0, SHALL immediately (asynchronously) force the following, and hold them while reset=0.
  - state=HUNT, exp_row=0.
  - Both banks all-zero, so rd_data=0.
  - frame_valid=0, frame_cnt=0, err_cnt=0, locked=0, scan_lost=0.
  - Synchronizer and history flops = 0, timeout counter = 0.
REQ-029 Reset asserted mid-frame SHALL discard the partial frame; after release, capture resumes only from the next row-0 sample.
REQ-030 A falling edge coincident with reset release SHALL be ignored because the history flop is 0.

Verification
REQ-031 Clean frames: drive rows 0..7 in order, enable=1, row r green=~(1<<r), red/blue=8'hFF -> exactly one frame_valid after row 7; frame_cnt=1; rd_data for row 3 = 24'h000800; err_cnt=0; locked=1.
REQ-032 Out of order: rows 0,1,2,5 -> err_cnt=1 and state HUNT after the row-5 sample; rows 6,7 produce no frame_valid; next 0..7 gives frame_cnt=1 and rd_data unchanged until that swap.
REQ-033 Duplicate row 0: rows 0,0,1..7 -> err_cnt=1, locked stays 1, frame_valid once, frame_cnt=1.
REQ-034 Enable low: rows 0..3, then a row-4 sample with enable=0, then rows 4..7 -> frame_valid once, err_cnt=0.
REQ-035 Timeout: TIMEOUT_CYC=1000, stop scan_clk after row 4 -> scan_lost=1 and locked=0 at cycle 1000; resume at row 5 -> no error and no frame until a complete 0..7.
REQ-036 Reset mid-frame: pull reset low after row 5 of the second frame -> all outputs 0 at once; after release, a full 0..7 gives frame_cnt=1 and err_cnt=0.
